// File: rtl/aes_invsubbytes_if.sv
// AES InvSubBytes stream interface: 128-bit state in, 128-bit state out,
// valid/ready handshake on each side. The design sits on the slave modport.
interface aes_invsubbytes_if;
    logic [127:0] data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] result;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output data, in_valid, out_ready,
        input  in_ready, result, out_valid
    );

    modport slave (
        input  data, in_valid, out_ready,
        output in_ready, result, out_valid
    );
endinterface

// File: rtl/aes_invsubbytes.sv
// AES InvSubBytes stage: applies the FIPS-197 inverse S-box to every byte of
// the 128-bit state. Default build shares 4 S-boxes across the four words,
// one word per cycle. Defining AES_INVSUBBYTES_FULLPAR_EN switches to 16
// parallel S-boxes that convert the whole state in a single BUSY cycle.
module aes_invsubbytes (
    input  logic            clk,
    input  logic            reset_n,
    aes_invsubbytes_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   result_q, result_d;
    logic           out_valid_q, out_valid_d;
    logic [127:0]   sub_work;
    logic           in_ready;
    logic           last_step;

`ifndef AES_INVSUBBYTES_FULLPAR_EN
    logic [6:0]     word_base;
    logic [31:0]    cur_word;
    logic [31:0]    new_word;
`endif

    // Ready when idle, or when the finished block is leaving this very cycle.
    assign in_ready      = reset_n & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign bus.in_ready  = in_ready;
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;

`ifdef AES_INVSUBBYTES_FULLPAR_EN
    // All 16 bytes substituted at once; the block finishes after one BUSY cycle.
    always_comb begin
        sub_work = work_q;
        for (int k = 0; k < 16; k++) begin
            sub_work[k*8 +: 8] = inv_sbox(work_q[k*8 +: 8]);
        end
        last_step = 1'b1;
    end
`else
    // Word wcnt (w0 is the most significant word) goes through the 4 shared S-boxes.
    always_comb begin
        word_base = {~wcnt_q, 5'b00000};
        cur_word  = work_q[word_base +: 32];
        new_word  = '0;
        for (int k = 0; k < 4; k++) begin
            new_word[k*8 +: 8] = inv_sbox(cur_word[k*8 +: 8]);
        end
        sub_work = work_q;
        sub_work[word_base +: 32] = new_word;
        last_step = (wcnt_q == 2'd3);
    end
`endif

    // Next-state logic: capture on input handshake, convert in BUSY, hold in DONE.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        work_d      = work_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    work_d  = bus.data;
                    wcnt_d  = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = sub_work;
                wcnt_d = wcnt_q + 2'd1;
                if (last_step) begin
                    result_d    = sub_work;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        work_d  = bus.data;
                        wcnt_d  = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any block in flight and clears the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wcnt_q      <= 2'd0;
            work_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            work_q      <= work_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
